// File: rtl/pmi_mc.sv
// Multi-channel processor memory interface: NCH round-robin requestors share one
// single-port word memory with wait states and byte-lane writes. Optional macro: PMI_MC_ADDR_CHECK_EN.
module pmi_mc #(
    parameter int NCH    = 2,
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int MEM_AW = 10,
    parameter int WAIT   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      req_rd,
    input  logic [NCH-1:0]      req_wr,
    input  logic [NCH*AW-1:0]   req_addr,
    input  logic [NCH*DW-1:0]   req_wdata,
    input  logic [NCH*DW/8-1:0] req_be,
    output logic [DW-1:0]       rdata,
    output logic [NCH-1:0]      mfc,
    output logic                busy,
    output logic                err
);
    localparam int BW = DW / 8;
    localparam int LB = $clog2(BW);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic [CW-1:0]       ptr_reg;
    logic [CW-1:0]       ch_reg;
    logic                wr_reg;
    logic [AW-1:0]       addr_reg;
    logic [DW-1:0]       wdata_reg;
    logic [BW-1:0]       be_reg;
    logic [DW-1:0]       rdata_reg;
    logic [NCH-1:0]      mfc_reg;
    logic                err_reg;

    logic [DW-1:0]       mem [2**MEM_AW];

    logic [AW-1:0]       addr_ch  [NCH];
    logic [DW-1:0]       wdata_ch [NCH];
    logic [BW-1:0]       be_ch    [NCH];
    logic [NCH-1:0]      active;
    logic                grant_found;
    logic [CW-1:0]       grant_id;
    int                  cand;
    logic                commit;
    logic                oor;
    logic [MEM_AW-1:0]   idx;
    logic                unused_addr;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign addr_ch[gi]  = req_addr[gi*AW +: AW];
            assign wdata_ch[gi] = req_wdata[gi*DW +: DW];
            assign be_ch[gi]    = req_be[gi*BW +: BW];
        end
    endgenerate

    assign active = req_rd | req_wr;

    // First requester strictly after the last granted channel, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int k = 1; k <= NCH; k++) begin
            cand = (int'(ptr_reg) + k) % NCH;
            if (!grant_found && active[cand]) begin
                grant_found = 1'b1;
                grant_id    = CW'(cand);
            end
        end
    end

    assign commit      = (state_reg == ACCESS) && (cnt_reg == 4'd0);
    assign idx         = addr_reg[MEM_AW+LB-1:LB];
    assign unused_addr = ^addr_reg;

`ifdef PMI_MC_ADDR_CHECK_EN
    assign oor = (addr_reg >> (MEM_AW + LB)) != '0;
`else
    assign oor = 1'b0;
`endif

    // Memory array has no reset; a commit edge that coincides with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_reg && !oor) begin
            for (int b = 0; b < BW; b++) begin
                if (be_reg[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_reg[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ptr_reg   <= CW'(NCH - 1);
            ch_reg    <= '0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            rdata_reg <= '0;
            mfc_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        ch_reg    <= grant_id;
                        ptr_reg   <= grant_id;
                        wr_reg    <= req_wr[grant_id];
                        addr_reg  <= addr_ch[grant_id];
                        wdata_reg <= wdata_ch[grant_id];
                        be_reg    <= be_ch[grant_id];
                        cnt_reg   <= 4'(WAIT);
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_reg == 4'd0) begin
                        if (!wr_reg) begin
                            rdata_reg <= oor ? '0 : mem[idx];
                        end
                        mfc_reg   <= NCH'(1) << ch_reg;
                        err_reg   <= oor;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                DONE: begin
                    mfc_reg   <= '0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rdata = rdata_reg;
    assign mfc   = mfc_reg;
    assign err   = err_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_pmi_mc.sv
// Bench for pmi_mc: directed scenarios plus randomized multi-channel traffic against
// a cycle-level reference model built from the arbitration, latency and memory rules.
module tb_pmi_mc;
    localparam int NCH    = 2;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int MEM_AW = 10;
    localparam int WAIT   = 2;
    localparam int LB     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      req_rd;
    logic [NCH-1:0]      req_wr;
    logic [NCH*AW-1:0]   req_addr;
    logic [NCH*DW-1:0]   req_wdata;
    logic [NCH*DW/8-1:0] req_be;
    logic [DW-1:0]       rdata;
    logic [NCH-1:0]      mfc;
    logic                busy;
    logic                err;

    pmi_mc #(.NCH(NCH), .DW(DW), .AW(AW), .MEM_AW(MEM_AW), .WAIT(WAIT)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .rdata(rdata), .mfc(mfc), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // requestor agents
    bit          pend   [NCH];
    bit          p_wr   [NCH];
    bit          p_both [NCH];
    logic [AW-1:0] p_addr [NCH];
    logic [DW-1:0] p_data [NCH];
    logic [3:0]  p_be   [NCH];
    int          cool   [NCH];
    bit          auto_gen;
    int          cool_max;

    // reference model
    int            cyc;
    int            m_ptr;
    int            m_free;
    bit            e_valid;
    int            e_ch;
    bit            e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [3:0]    e_be;
    int            e_done;
    logic [DW-1:0] ref_rdata;
    logic [DW-1:0] ref_mem [int];
    int            done_ch;
    bit            last_err;
    int            order_q [$];

    function automatic int word_idx(input logic [AW-1:0] a);
        return int'((a >> LB) & ((1 << MEM_AW) - 1));
    endfunction

    function automatic bit out_of_range(input logic [AW-1:0] a);
`ifdef PMI_MC_ADDR_CHECK_EN
        return (a >> (MEM_AW + LB)) != 0;
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    task automatic drive_inputs();
        for (int c = 0; c < NCH; c++) begin
            req_rd[c]                = pend[c] && (!p_wr[c] || p_both[c]);
            req_wr[c]                = pend[c] && p_wr[c];
            req_addr[c*AW +: AW]     = p_addr[c];
            req_wdata[c*DW +: DW]    = p_data[c];
            req_be[c*4 +: 4]         = p_be[c];
        end
    endtask

    task automatic gen(input int c);
        int w;
        w         = $urandom_range(0, 7);
        p_wr[c]   = $urandom_range(0, 1) == 1;
        p_both[c] = p_wr[c] && ($urandom_range(0, 3) == 0);
        p_addr[c] = (32'(w) << LB) | 32'($urandom_range(0, 3)) |
                    (($urandom_range(0, 5) == 0) ? 32'h1000 : 32'h0);
        p_data[c] = $urandom;
        p_be[c]   = 4'($urandom_range(0, 15));
        pend[c]   = 1'b1;
    endtask

    // One clock: model the grant at the edge, then check all outputs mid-cycle.
    task automatic step();
        logic [NCH-1:0] exp_mfc;
        bit             exp_err;
        bit             oor;
        int             idx;
        logic [DW-1:0]  nv;
        @(posedge clk);
        cyc++;
        if (rst) begin
            e_valid   = 1'b0;
            m_ptr     = NCH - 1;
            m_free    = cyc + 1;
            ref_rdata = '0;
        end else if (!e_valid && cyc >= m_free && (|(req_rd | req_wr))) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (req_rd[c] || req_wr[c]) begin
                    e_ch = c;
                    break;
                end
            end
            e_wr    = req_wr[e_ch];
            e_addr  = req_addr[e_ch*AW +: AW];
            e_data  = req_wdata[e_ch*DW +: DW];
            e_be    = req_be[e_ch*4 +: 4];
            e_done  = cyc + WAIT + 1;
            m_ptr   = e_ch;
            m_free  = cyc + WAIT + 3;
            e_valid = 1'b1;
        end
        @(negedge clk);
        done_ch = -1;
        exp_mfc = '0;
        exp_err = 1'b0;
        if (e_valid && cyc == e_done) begin
            exp_mfc[e_ch] = 1'b1;
            oor     = out_of_range(e_addr);
            exp_err = oor;
            idx     = word_idx(e_addr);
            if (e_wr) begin
                if (!oor) begin
                    nv = ref_mem.exists(idx) ? ref_mem[idx] : 'x;
                    for (int b = 0; b < 4; b++) if (e_be[b]) nv[b*8 +: 8] = e_data[b*8 +: 8];
                    ref_mem[idx] = nv;
                end
            end else begin
                ref_rdata = oor ? '0 : (ref_mem.exists(idx) ? ref_mem[idx] : 'x);
            end
            done_ch = e_ch;
            $display("txn cyc=%0d ch=%0d %s addr=%08h wdata=%08h be=%h rdata=%08h err=%0d",
                     cyc, e_ch, e_wr ? "WR" : "RD", e_addr, e_data, e_be, rdata, err);
        end
        check_val("mfc", mfc, exp_mfc);
        check_val("busy", busy, e_valid);
        check_val("err", err, exp_err);
        check_val("rdata", rdata, ref_rdata);
        if (done_ch >= 0) begin
            e_valid  = 1'b0;
            last_err = err;
            order_q.push_back(done_ch);
        end
        for (int c = 0; c < NCH; c++) begin
            if (!pend[c] && auto_gen) begin
                if (cool[c] > 0) cool[c]--;
                else gen(c);
            end
        end
        if (done_ch >= 0) begin
            pend[done_ch] = 1'b0;
            cool[done_ch] = $urandom_range(1, cool_max);
        end
        drive_inputs();
    endtask

    task automatic do_op(input int ch, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [3:0] be, input bit both);
        int  start;
        bit  got;
        step();
        pend[ch]   = 1'b1;
        p_wr[ch]   = wr;
        p_both[ch] = both;
        p_addr[ch] = addr;
        p_data[ch] = data;
        p_be[ch]   = be;
        drive_inputs();
        start = cyc + 1;
        got   = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            step();
            if (done_ch == ch) got = 1'b1;
        end
        if (!got) begin
            check_val("timeout", 0, 1);
            pend[ch] = 1'b0;
            drive_inputs();
        end else begin
            check_val("latency", cyc - start, WAIT + 1);
        end
    endtask

    initial begin
        bit ok;
        rst       = 1'b1;
        auto_gen  = 1'b0;
        cool_max  = 1;
        cyc       = 0;
        m_ptr     = NCH - 1;
        m_free    = 0;
        e_valid   = 1'b0;
        ref_rdata = '0;
        last_err  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            pend[c] = 1'b0; p_wr[c] = 1'b0; p_both[c] = 1'b0;
            p_addr[c] = '0; p_data[c] = '0; p_be[c] = '0; cool[c] = 0;
        end
        drive_inputs();
        step();
        step();
        check_val("rst_busy", busy, 0);
        check_val("rst_mfc", mfc, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_err", err, 0);
        rst = 1'b0;

        for (int w = 0; w < 10; w++) do_op(w % 2, 1'b1, 32'(w) << LB, $urandom, 4'hF, 1'b0);

        do_op(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        do_op(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        check_val("basic_rd", rdata, 32'hDEADBEEF);

        do_op(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
        do_op(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
        do_op(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        check_val("byte_lanes", rdata, 32'h11BB33DD);

        do_op(1, 1'b0, 32'h13, 32'h0, 4'h0, 1'b0);
        check_val("misaligned", rdata, 32'hDEADBEEF);

        do_op(0, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 1'b1);
        do_op(1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
        check_val("rd_wr_both", rdata, 32'hCAFEF00D);

        // reset lands while the write is still counting down (cnt==1)
        step();
        pend[0] = 1'b1; p_wr[0] = 1'b1; p_both[0] = 1'b0;
        p_addr[0] = 32'h10; p_data[0] = 32'h12345678; p_be[0] = 4'hF;
        drive_inputs();
        step();
        step();
        rst     = 1'b1;
        pend[0] = 1'b0;
        drive_inputs();
        step();
        rst = 1'b0;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_mfc", mfc, 0);
        do_op(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        check_val("mid_rst_mem", rdata, 32'hDEADBEEF);

        do_op(0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, 1'b0);
        do_op(0, 1'b1, 32'h1000, 32'h0BADF00D, 4'hF, 1'b0);
`ifdef PMI_MC_ADDR_CHECK_EN
        check_val("ac_err", last_err, 1);
        do_op(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0);
        check_val("ac_rd_oor", rdata, 32'h0);
        do_op(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check_val("ac_mem0", rdata, 32'h55AA55AA);
`else
        check_val("ac_err", last_err, 0);
        do_op(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0);
        check_val("alias_rd", rdata, 32'h0BADF00D);
        do_op(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check_val("alias_mem0", rdata, 32'h0BADF00D);
`endif

        // contention: both channels requesting continuously from reset
        rst = 1'b1;
        step();
        order_q.delete();
        auto_gen = 1'b1;
        cool_max = 1;
        gen(0);
        gen(1);
        drive_inputs();
        step();
        rst = 1'b0;
        for (int t = 0; t < 100 && order_q.size() < 4; t++) step();
        ok = order_q.size() >= 4;
        check_val("rr_count", ok, 1);
        if (ok) for (int i = 0; i < 4; i++) check_val("rr_order", order_q[i], i % 2);

        cool_max = 4;
        for (int t = 0; t < 800; t++) step();
        auto_gen = 1'b0;
        for (int t = 0; t < 60 && (pend[0] || pend[1] || e_valid); t++) step();
        check_val("drain", pend[0] || pend[1] || e_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
